// File: rtl/neuron_feeder.sv
// Time-multiplexes one streaming neuron across a layer: reads pixels, weights and biases, then writes one result per neuron.
// Optional bias path: define FEEDER_BIAS_EN to read per-neuron biases; otherwise the bias is tied to zero.
module neuron_feeder #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned NUM_INPUTS  = 784,
  parameter int unsigned NUM_NEURONS = 10,
  localparam int unsigned PIX_AW = $clog2(NUM_INPUTS),
  localparam int unsigned WT_AW  = $clog2(NUM_INPUTS * NUM_NEURONS),
  localparam int unsigned N_AW   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic [PIX_AW-1:0]     pix_addr,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic [WT_AW-1:0]      wt_addr,
  input  logic [DATA_WIDTH-1:0] wt_data,
  output logic [N_AW-1:0]       bias_addr,
  input  logic [DATA_WIDTH-1:0] bias_data,
  output logic [DATA_WIDTH-1:0] nrn_data_in,
  output logic [DATA_WIDTH-1:0] nrn_weight_in,
  output logic [DATA_WIDTH-1:0] nrn_bias_in,
  output logic                  nrn_input_valid,
  input  logic [OUT_WIDTH-1:0]  nrn_data_out,
  input  logic                  nrn_out_valid,
  output logic                  res_we,
  output logic [N_AW-1:0]       res_addr,
  output logic [OUT_WIDTH-1:0]  res_data
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_e;

  localparam logic [PIX_AW-1:0] K_LAST = PIX_AW'(NUM_INPUTS - 1);
  localparam logic [N_AW-1:0]   N_LAST = N_AW'(NUM_NEURONS - 1);

  state_e                state_q;
  logic [PIX_AW-1:0]     k_q;
  logic [N_AW-1:0]       n_q;
  logic                  issue_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  res_we_q;
  logic [PIX_AW-1:0]     pix_addr_q;
  logic [WT_AW-1:0]      wt_addr_q;
  logic [N_AW-1:0]       bias_addr_q;
  logic [N_AW-1:0]       res_addr_q;
  logic [OUT_WIDTH-1:0]  res_data_q;
  logic [N_AW-1:0]       bias_n_c;

`ifdef FEEDER_BIAS_EN
  assign bias_n_c    = n_q;
  assign nrn_bias_in = bias_data;
`else
  logic unused_bias_c;
  assign unused_bias_c = ^bias_data;
  assign bias_n_c      = '0;
  assign nrn_bias_in   = '0;
`endif

  // Beat 0 of the first neuron issues on the accepting edge; later neurons restart from k=0 in STREAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      n_q         <= '0;
      issue_q     <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_we_q    <= 1'b0;
      pix_addr_q  <= '0;
      wt_addr_q   <= '0;
      bias_addr_q <= '0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
    end else begin
      issue_q  <= 1'b0;
      valid_q  <= issue_q;
      done_q   <= 1'b0;
      res_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_STREAM;
            busy_q      <= 1'b1;
            n_q         <= '0;
            k_q         <= PIX_AW'(1);
            issue_q     <= 1'b1;
            pix_addr_q  <= '0;
            wt_addr_q   <= '0;
            bias_addr_q <= '0;
          end
        end
        S_STREAM: begin
          if (!hold) begin
            issue_q     <= 1'b1;
            pix_addr_q  <= k_q;
            wt_addr_q   <= wt_addr_q + WT_AW'(1);
            bias_addr_q <= bias_n_c;
            k_q         <= k_q + PIX_AW'(1);
            if (k_q == K_LAST) state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (nrn_out_valid) begin
            res_we_q   <= 1'b1;
            res_addr_q <= n_q;
            res_data_q <= nrn_data_out;
            if (n_q == N_LAST) begin
              state_q <= S_DONE;
            end else begin
              n_q     <= n_q + N_AW'(1);
              k_q     <= '0;
              state_q <= S_STREAM;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pix_addr        = pix_addr_q;
  assign wt_addr         = wt_addr_q;
  assign bias_addr       = bias_addr_q;
  assign nrn_data_in     = pix_data;
  assign nrn_weight_in   = wt_data;
  assign nrn_input_valid = valid_q;
  assign res_we          = res_we_q;
  assign res_addr        = res_addr_q;
  assign res_data        = res_data_q;

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder: table of layer runs on a 4-input/2-neuron instance plus a default-size timing run.
module tb_neuron_feeder;

`ifdef FEEDER_BIAS_EN
  localparam bit BIAS_ON = 1'b1;
`else
  localparam bit BIAS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, hold, start_b;
  logic        busy, done, nrn_input_valid, res_we, nrn_out_valid;
  logic [1:0]  pix_addr;
  logic [2:0]  wt_addr;
  logic [0:0]  bias_addr, res_addr;
  logic [15:0] pix_data, wt_data, bias_data;
  logic [15:0] nrn_data_in, nrn_weight_in, nrn_bias_in, nrn_data_out, res_data;

  neuron_feeder #(.DATA_WIDTH(16), .OUT_WIDTH(16), .NUM_INPUTS(4), .NUM_NEURONS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
    .pix_addr(pix_addr), .pix_data(pix_data), .wt_addr(wt_addr), .wt_data(wt_data),
    .bias_addr(bias_addr), .bias_data(bias_data),
    .nrn_data_in(nrn_data_in), .nrn_weight_in(nrn_weight_in), .nrn_bias_in(nrn_bias_in),
    .nrn_input_valid(nrn_input_valid), .nrn_data_out(nrn_data_out), .nrn_out_valid(nrn_out_valid),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
  );

  logic [15:0] pix_mem [4];
  logic [15:0] wt_mem [8];
  logic [15:0] bias_mem [2];

  always_ff @(posedge clk) begin
    pix_data  <= pix_mem[pix_addr];
    wt_data   <= wt_mem[wt_addr];
    bias_data <= bias_mem[bias_addr];
  end

  // Behavioural Q1.15 neuron: accumulates 4 products, adds bias on the last beat.
  logic signed [31:0] prod, acc, bias_ext;
  logic [1:0]         nbeat;
  assign prod     = ($signed(nrn_data_in) * $signed(nrn_weight_in)) >>> 15;
  assign bias_ext = $signed({{16{nrn_bias_in[15]}}, nrn_bias_in});

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0; nbeat <= '0; nrn_out_valid <= 1'b0; nrn_data_out <= '0;
    end else begin
      nrn_out_valid <= 1'b0;
      if (nrn_input_valid) begin
        if (nbeat == 2'd3) begin
          nrn_data_out  <= 16'(acc + prod + bias_ext);
          nrn_out_valid <= 1'b1;
          acc           <= '0;
          nbeat         <= '0;
        end else begin
          acc   <= acc + prod;
          nbeat <= nbeat + 2'd1;
        end
      end
    end
  end

  // Default-size instance with a beat-counting neuron stand-in.
  logic        b_done, b_valid, b_res_we, b_ov, unused_b_busy;
  logic [9:0]  b_pix_addr, b_beat;
  logic [12:0] b_wt_addr;
  logic [3:0]  b_bias_addr, b_res_addr;
  logic [15:0] unused_b_din, unused_b_win, unused_b_bin, b_res_data;

  neuron_feeder big (
    .clk(clk), .rst(rst), .start(start_b), .hold(1'b0), .busy(unused_b_busy), .done(b_done),
    .pix_addr(b_pix_addr), .pix_data(16'h0000), .wt_addr(b_wt_addr), .wt_data(16'h0000),
    .bias_addr(b_bias_addr), .bias_data(16'h0000),
    .nrn_data_in(unused_b_din), .nrn_weight_in(unused_b_win), .nrn_bias_in(unused_b_bin),
    .nrn_input_valid(b_valid), .nrn_data_out(16'h5A5A), .nrn_out_valid(b_ov),
    .res_we(b_res_we), .res_addr(b_res_addr), .res_data(b_res_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      b_beat <= '0; b_ov <= 1'b0;
    end else begin
      b_ov <= 1'b0;
      if (b_valid) begin
        if (b_beat == 10'd783) begin b_beat <= '0; b_ov <= 1'b1; end
        else b_beat <= b_beat + 10'd1;
      end
    end
  end

  int total, bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0][15:0] pix;
    logic [7:0][15:0] wt;
    logic [1:0][15:0] bias;
    int hold_at, hold_len, restart_at, rst_at;
    logic [1:0][15:0] exp_res;
    int exp_done, exp_nres;
  } row_t;

  row_t rows[6];

  task automatic run_row(input int r);
    row_t t;
    int vb, nres, ndone, done_cyc, first_v, stop_at;
    logic [2:0]  prev_wt;
    logic [15:0] eb;
    t = rows[r];
    for (int i = 0; i < 4; i++) pix_mem[i] = t.pix[i];
    for (int i = 0; i < 8; i++) wt_mem[i] = t.wt[i];
    for (int i = 0; i < 2; i++) bias_mem[i] = t.bias[i];
    vb = 0; nres = 0; ndone = 0; done_cyc = -1; first_v = -1; prev_wt = '0;
    stop_at = (t.rst_at > 0) ? t.rst_at + 20 : 60;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("r%0d busy_c1", r), 32'(busy), 32'd1);
    for (int cyc = 1; cyc < stop_at; cyc++) begin
      hold  = (cyc >= t.hold_at) && (cyc < t.hold_at + t.hold_len);
      start = (t.restart_at > 0) && (cyc == t.restart_at || cyc == t.restart_at + 5);
      if (nrn_input_valid) begin
        if (first_v < 0) first_v = cyc;
        eb = BIAS_ON ? t.bias[nres] : 16'h0000;
        chk($sformatf("r%0d pix n%0d b%0d", r, nres, vb), 32'(nrn_data_in), 32'(t.pix[vb]));
        chk($sformatf("r%0d wt n%0d b%0d", r, nres, vb), 32'(nrn_weight_in), 32'(t.wt[nres*4+vb]));
        chk($sformatf("r%0d bias n%0d b%0d", r, nres, vb), 32'(nrn_bias_in), 32'(eb));
        chk($sformatf("r%0d wt_addr n%0d b%0d", r, nres, vb), 32'(prev_wt), 32'(nres*4+vb));
        vb++;
      end
      if (res_we) begin
        chk($sformatf("r%0d res_addr", r), 32'(res_addr), 32'(nres));
        chk($sformatf("r%0d res_data", r), 32'(res_data), 32'(t.exp_res[nres]));
        chk($sformatf("r%0d beats", r), 32'(vb), 32'd4);
        vb = 0;
        nres++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = cyc; stop_at = cyc + 3; end
        chk($sformatf("r%0d busy_at_done", r), 32'(busy), 32'd0);
      end
      prev_wt = wt_addr;
      if (t.rst_at > 0 && cyc == t.rst_at) rst = 1'b1;
      else if (t.rst_at > 0 && (cyc == t.rst_at + 1 || cyc == t.rst_at + 2)) begin
        chk($sformatf("r%0d outputs_in_rst", r),
            32'({busy, done, pix_addr, wt_addr, bias_addr, nrn_input_valid, res_we, res_addr, res_data}), 32'd0);
        if (cyc == t.rst_at + 2) rst = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk($sformatf("r%0d done_cycle", r), 32'(done_cyc), 32'(t.exp_done));
    chk($sformatf("r%0d results", r), 32'(nres), 32'(t.exp_nres));
    chk($sformatf("r%0d done_pulses", r), 32'(ndone), (t.exp_done > 0) ? 32'd1 : 32'd0);
    chk($sformatf("r%0d first_valid", r), 32'(first_v), 32'd2);
    hold = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int bw, bv, bdone;
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; hold = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 4; i++) pix_mem[i] = '0;
    for (int i = 0; i < 8; i++) wt_mem[i] = '0;
    for (int i = 0; i < 2; i++) bias_mem[i] = '0;

    for (int r = 0; r < 6; r++) begin
      rows[r].pix = {4{16'h4000}};
      rows[r].wt = {8{16'h4000}};
      rows[r].bias = '0;
      rows[r].hold_at = 0; rows[r].hold_len = 0; rows[r].restart_at = 0; rows[r].rst_at = 0;
      rows[r].exp_res = {2{16'h8000}};
      rows[r].exp_done = 15; rows[r].exp_nres = 2;
    end
    // back-pressure with distinct data so beat pairing is visible
    rows[1].pix = {16'h0800, 16'h1000, 16'h2000, 16'h4000};
    rows[1].wt = {{4{16'h2000}}, {4{16'h4000}}};
    rows[1].hold_at = 2; rows[1].hold_len = 3;
    rows[1].exp_res = {16'h1E00, 16'h3C00};
    rows[1].exp_done = 18;
    rows[2].bias = {16'hE000, 16'h2000};
    rows[2].exp_res = BIAS_ON ? {16'h6000, 16'hA000} : {2{16'h8000}};
    rows[3].restart_at = 5;
    rows[4].rst_at = 9;
    rows[4].exp_done = -1; rows[4].exp_nres = 1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", 32'({busy, done, pix_addr, wt_addr, bias_addr, nrn_input_valid, res_we, res_addr, res_data}), 32'd0);
    chk("reset big outputs", 32'({b_done, b_valid, b_res_we, b_pix_addr, b_wt_addr, b_bias_addr, b_res_addr}), 32'd0);
    chk("reset big res_data", 32'(b_res_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < 6; r++) run_row(r);

    bw = 0; bv = 0; bdone = -1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 1; c < 9000; c++) begin
      if (b_valid) bv++;
      if (b_res_we) begin
        chk($sformatf("big res_addr %0d", bw), 32'(b_res_addr), 32'(bw));
        chk($sformatf("big res_data %0d", bw), 32'(b_res_data), 32'h5A5A);
        bw++;
      end
      if (b_done) begin bdone = c; break; end
      @(posedge clk); #1;
    end
    chk("big done_cycle", 32'(bdone), 32'd7871);
    chk("big writes", 32'(bw), 32'd10);
    chk("big beats", 32'(bv), 32'd7840);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
